// File: rtl/data_mem_responder.sv
// Data memory responder for the load/store stage: byte-addressed
// RV32I accesses with fixed wait states and a one-cycle ready pulse.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [AW-1:0]  idx_q;
  logic [1:0]     lane_q;
  logic [31:0]    wdata_q;
  logic           bad_q;
  logic           ready_q;
  logic           busy_q;
  logic           err_q;
  logic [31:0]    rdata_q;

  logic [31:0] mem_q [DEPTH];

  logic        bad_d;
  logic        f3_ok;
  logic        mis;
  logic        oor;
  logic        fire;
  logic [3:0]  be;
  logic [31:0] wsh;
  logic [31:0] word;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] ld;

  always_comb begin
    f3_ok = 1'b0;
    mis   = 1'b0;
    oor   = |addr[31:AW+2];
    if (we) f3_ok = f3 inside {3'b000, 3'b001, 3'b010};
    else    f3_ok = f3 inside {3'b000, 3'b001, 3'b010,
                               3'b100, 3'b101};
    unique case (1'b1)
      f3[1:0] == 2'b01: mis = addr[0];
      f3[1:0] == 2'b10: mis = |addr[1:0];
      default:          mis = 1'b0;
    endcase
    bad_d = !f3_ok || mis || oor;
  end

  // Store lanes: source bits always come from lane 0 of wdata.
  always_comb begin
    be  = 4'b1111;
    wsh = wdata_q;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: begin
        be  = 4'b0001 << lane_q;
        wsh = {4{wdata_q[7:0]}};
      end
      f3_q[1:0] == 2'b01: begin
        be  = lane_q[1] ? 4'b1100 : 4'b0011;
        wsh = {2{wdata_q[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        wsh = wdata_q;
      end
    endcase
  end

  always_comb begin
    word = mem_q[idx_q];
    rb   = word[{lane_q, 3'b000} +: 8];
    rh   = lane_q[1] ? word[31:16] : word[15:0];
    unique case (f3_q)
      3'b000:  ld = {{24{rb[7]}}, rb};
      3'b100:  ld = {24'd0, rb};
      3'b001:  ld = {{16{rh[15]}}, rh};
      3'b101:  ld = {16'd0, rh};
      default: ld = word;
    endcase
  end

  assign fire = (state_q == WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (fire && we_q && !bad_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx_q][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      bad_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= WAIT;
            cnt_q   <= WAIT_STATES[3:0];
            we_q    <= we;
            f3_q    <= f3;
            idx_q   <= addr[AW+1:2];
            lane_q  <= addr[1:0];
            wdata_q <= wdata;
            bad_q   <= bad_d;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= bad_q;
            rdata_q <= (bad_q || we_q) ? 32'd0 : ld;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-array memory model,
// latency, error, abort-on-reset and back-to-back request checks.
module tb_data_mem_responder;

  localparam int W = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [2:0]  f3    = 3'd0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  logic        req0   = 1'b0;
  logic        we0    = 1'b0;
  logic [2:0]  f30    = 3'b011;
  logic [31:0] addr0  = 32'd0;
  logic [31:0] wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ready0;
  logic        busy0;
  logic        err0;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mb [0:1023];
  logic [32:0] sbq [$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .f3(f3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .busy(busy), .err(err)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .f3(f30),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0),
    .busy(busy0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] r);
    int  n;
    logic ok;
    r = '0;
    n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    if (w) ok = f inside {3'd0, 3'd1, 3'd2};
    else   ok = f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    e = !ok || (a % n != 0) || (a >= 32'd1024);
    if (e) return;
    if (w) begin
      for (int i = 0; i < n; i++) mb[a+i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) r[8*i +: 8] = mb[a+i];
      if (!f[2] && n == 1) r = {{24{r[7]}}, r[7:0]};
      if (!f[2] && n == 2) r = {{16{r[15]}}, r[15:0]};
    end
  endtask

  task automatic xfer(input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] obs, output logic oe);
    logic        e;
    logic [31:0] r;
    logic [32:0] x;
    int          n;
    obs = '0;
    oe  = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    model(w, f, a, d, e, r);
    sbq.push_back({e, r});
    @(posedge clk); #1;
    chk("busy_cap", busy, 1);
    chk("rdy_cap", ready, 0);
    @(negedge clk);
    req = 1'b0; we = ~w; f3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    x = sbq.pop_front();
    if (ready !== 1'b1) begin
      chk("timeout", ready, 1);
      return;
    end
    chk("latency", n, W + 1);
    chk("err", err, x[32]);
    chk("rdata", rdata, x[31:0]);
    chk("busy_resp", busy, 1);
    obs = rdata;
    oe  = err;
    @(posedge clk); #1;
    chk("rdy_end", ready, 0);
    chk("busy_end", busy, 0);
    chk("rd_idle", rdata, 0);
    chk("err_idle", err, 0);
  endtask

  initial begin
    logic [31:0] o;
    logic [31:0] p;
    logic        oe;
    logic        w;
    logic [2:0]  ft [6];
    logic [31:0] a;

    ft = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

    #12;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy0", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++)
      xfer(1'b1, 3'b010, 32'(4 * i), $urandom, o, oe);

    xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o, oe);
    chk("sw10_err", oe, 0);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, o, oe);
    chk("lw10", o, 32'hDEADBEEF);

    xfer(1'b1, 3'b000, 32'h11, 32'h000000A5, o, oe);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, o, oe);
    chk("lw10_sb", o, 32'hDEADA5EF);
    xfer(1'b0, 3'b000, 32'h11, 32'h0, o, oe);
    chk("lb11", o, 32'hFFFFFFA5);
    xfer(1'b0, 3'b100, 32'h11, 32'h0, o, oe);
    chk("lbu11", o, 32'h000000A5);

    xfer(1'b1, 3'b001, 32'h22, 32'h00008001, o, oe);
    xfer(1'b0, 3'b001, 32'h22, 32'h0, o, oe);
    chk("lh22", o, 32'hFFFF8001);
    xfer(1'b0, 3'b101, 32'h22, 32'h0, o, oe);
    chk("lhu22", o, 32'h00008001);
    xfer(1'b0, 3'b010, 32'h20, 32'h0, o, oe);
    chk("lw20_hi", o[31:16], 32'h8001);
    p = o;

    xfer(1'b0, 3'b010, 32'h13, 32'h0, o, oe);
    chk("lw13_err", oe, 1);
    chk("lw13_rd", o, 0);
    xfer(1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, o, oe);
    chk("sh21_err", oe, 1);
    xfer(1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, o, oe);
    chk("sw400_err", oe, 1);
    xfer(1'b0, 3'b011, 32'h10, 32'h0, o, oe);
    chk("f3_ld_err", oe, 1);
    xfer(1'b1, 3'b100, 32'h10, 32'h0, o, oe);
    chk("f3_st_err", oe, 1);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, o, oe);
    chk("lw10_keep", o, 32'hDEADA5EF);
    xfer(1'b0, 3'b010, 32'h20, 32'h0, o, oe);
    chk("lw20_keep", o, p);

    xfer(1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, o, oe);
    xfer(1'b0, 3'b010, 32'h3FC, 32'h0, o, oe);
    chk("lw3fc", o, 32'hCAFEF00D);

    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom_range(1));
      a = 32'h40 + 32'($urandom_range(63));
      if (k % 10 == 9) a = a + 32'h400;
      xfer(w, ft[$urandom_range(5)], a, $urandom, o, oe);
    end

    xfer(1'b0, 3'b010, 32'h30, 32'h0, p, oe);
    @(negedge clk);
    req = 1'b1; we = 1'b1; f3 = 3'b010;
    addr = 32'h30; wdata = 32'h12345678;
    @(posedge clk); #1;
    chk("ab_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    chk("ab_busy0", busy, 0);
    chk("ab_rdy0", ready, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("ab_rst_rdy", ready, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("ab_no_rdy", ready, 0);
      chk("ab_no_busy", busy, 0);
    end
    xfer(1'b0, 3'b010, 32'h30, 32'h0, o, oe);
    chk("ab_lw30", o, p);

    @(negedge clk);
    req0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("b2b_rdy", ready0, 32'(i % 3 == 1));
      chk("b2b_busy", busy0, 32'(i % 3 != 2));
      chk("b2b_err", err0, 32'(i % 3 == 1));
    end
    @(negedge clk);
    req0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
